jtag_dma_arbiter: RTL and testbench

Parametrised command arbiter between N JTAG instruction chains and the single system DMA controller. It runs on the system clock domain, behind the per-chain JTCK-to-system synchronisers. It accepts read/write/buffer-switch commands from each chain over a valid/ready handshake and serialises them onto the DMA launch interface using round-robin grant. Each command gets a per-channel done or error pulse, with a timeout guard and a status byte.

---
 rtl/jtag_dma_pkg.sv | 35 +++
 rtl/jtag_dma_arbiter_rr.sv | 64 ++++++
 rtl/jtag_dma_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_jtag_dma_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/jtag_dma_pkg.sv
// Shared encodings for the JTAG-to-DMA command arbiter: op codes, FSM states
// and the layout of the status byte.
package jtag_dma_pkg;

  typedef enum logic [1:0] {
    OP_READ   = 2'b00,
    OP_WRITE  = 2'b01,
    OP_SWITCH = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_RESPOND   = 3'd3
  } state_e;

  localparam int unsigned STATUS_STATE_LSB   = 0;
  localparam int unsigned STATUS_STATE_W     = 3;
  localparam int unsigned STATUS_TIMEOUT_BIT = 3;
  localparam int unsigned STATUS_GRANT_LSB   = 4;
  localparam int unsigned STATUS_GRANT_W     = 4;

  function automatic logic [7:0] pack_status(input state_e st, input logic timeout,
                                             input logic [3:0] grant);
    logic [7:0] s;
    s = 8'h00;
    s[STATUS_STATE_LSB +: STATUS_STATE_W] = st;
    s[STATUS_TIMEOUT_BIT]                 = timeout;
    s[STATUS_GRANT_LSB +: STATUS_GRANT_W] = grant;
    return s;
  endfunction

endpackage

// File: rtl/jtag_dma_arbiter_rr.sv
// Round-robin arbiter: the search starts one past the last granted index and
// the last-grant register only moves when the caller strobes update_i.
module rr_arbiter
  import jtag_dma_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_i,
  input  logic             update_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             valid_o,
  output logic [IDX_W-1:0] last_idx_o
);

  logic [IDX_W-1:0] last_q;

  // Rotating priority search over the request vector.
  always_comb begin
    int   cand_s;
    logic found_s;
    cand_s      = 0;
    found_s     = 1'b0;
    grant_idx_o = last_q;
    for (int k = 1; k <= int'(N); k++) begin
      cand_s = int'(last_q) + k;
      if (cand_s >= int'(N)) begin
        cand_s = cand_s - int'(N);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req_i[cand_s]) begin
        found_s     = 1'b1;
        grant_idx_o = IDX_W'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
    valid_o = found_s;
    grant_o = '0;
    if (found_s) begin
      grant_o[grant_idx_o] = 1'b1;
    end else begin
      grant_o = '0;
    end
  end

  // Last-grant register; resets to N-1 so index 0 wins first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= IDX_W'(N - 1);
    end else if (update_i) begin
      last_q <= grant_idx_o;
    end else begin
      last_q <= last_q;
    end
  end

  assign last_idx_o = last_q;

endmodule

// File: rtl/jtag_dma_arbiter.sv
// Serialises per-chain JTAG commands onto the single DMA launch interface with
// round-robin grant, per-channel done/error pulses and a completion timeout.
module jtag_dma_arbiter
  import jtag_dma_pkg::*;
#(
  parameter int unsigned N_CH           = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned BURST_W        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  system_clk_i,
  input  logic                  system_reset_i,
  input  logic [N_CH-1:0]       cmd_valid_i,
  output logic [N_CH-1:0]       cmd_ready_o,
  input  logic [2*N_CH-1:0]     cmd_op_i,
  input  logic [ADDR_W*N_CH-1:0]  cmd_address_i,
  input  logic [BURST_W*N_CH-1:0] cmd_burst_size_i,
  input  logic [4*N_CH-1:0]     cmd_byte_enable_i,
  input  logic [8*N_CH-1:0]     cmd_block_size_i,
  output logic [N_CH-1:0]       rsp_done_o,
  output logic [N_CH-1:0]       rsp_error_o,
  output logic [7:0]            rsp_block_size_o,
  output logic [ADDR_W-1:0]     dma_address_o,
  output logic [BURST_W-1:0]    dma_burst_size_out_o,
  output logic [3:0]            dma_byte_enable_o,
  output logic [7:0]            dma_block_size_out_o,
  output logic                  dma_launch_read_o,
  output logic                  dma_launch_write_o,
  output logic                  dma_launch_simple_switch_o,
  input  logic                  dma_busy_i,
  input  logic                  dma_operation_done_i,
  input  logic [7:0]            dma_block_size_in_i,
  output logic [7:0]            status_out_o
);

  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] ch_q, ch_d;
  logic             sticky_q, sticky_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [3:0]       be_q, be_d;
  logic [7:0]       bs_q, bs_d;
  logic             rd_q, rd_d, wr_q, wr_d, sw_q, sw_d;
  logic [N_CH-1:0]  done_q, done_d, err_q, err_d;
  logic [7:0]       rbs_q, rbs_d;

  logic [N_CH-1:0]  grant_s;
  logic [IDX_W-1:0] grant_idx_s, last_idx_s;
  logic             grant_any_s, arb_open_s, handshake_s;
  op_e              sel_op_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [BURST_W-1:0] sel_burst_s;
  logic [3:0]       sel_be_s;
  logic [7:0]       sel_bs_s;

  function automatic logic [N_CH-1:0] ch_onehot(input logic [IDX_W-1:0] idx);
    logic [N_CH-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  rr_arbiter #(.N(N_CH), .IDX_W(IDX_W)) u_rr (
    .clk_i      (system_clk_i),
    .rst_i      (system_reset_i),
    .req_i      (cmd_valid_i),
    .update_i   (handshake_s),
    .grant_o    (grant_s),
    .grant_idx_o(grant_idx_s),
    .valid_o    (grant_any_s),
    .last_idx_o (last_idx_s)
  );

  // Ready is offered only in IDLE with the DMA free and reset released.
  assign arb_open_s  = (state_q == ST_IDLE) && !dma_busy_i && !system_reset_i;
  assign handshake_s = arb_open_s && grant_any_s;
  assign cmd_ready_o = arb_open_s ? grant_s : '0;

  // Mux out the winning channel's command fields.
  always_comb begin
    sel_op_s    = op_e'(cmd_op_i[2*int'(grant_idx_s) +: 2]);
    sel_addr_s  = cmd_address_i[ADDR_W*int'(grant_idx_s) +: ADDR_W];
    sel_burst_s = cmd_burst_size_i[BURST_W*int'(grant_idx_s) +: BURST_W];
    sel_be_s    = cmd_byte_enable_i[4*int'(grant_idx_s) +: 4];
    sel_bs_s    = cmd_block_size_i[8*int'(grant_idx_s) +: 8];
  end

  // Next-state and registered-output logic of the command FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    sticky_d = sticky_q;
    addr_d   = addr_q;
    burst_d  = burst_q;
    be_d     = be_q;
    bs_d     = bs_q;
    rbs_d    = rbs_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    sw_d     = 1'b0;
    done_d   = '0;
    err_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (handshake_s) begin
          ch_d = grant_idx_s;
          if (sel_op_s == OP_RSVD) begin
            state_d = ST_RESPOND;
            err_d   = ch_onehot(grant_idx_s);
          end else begin
            state_d = ST_LAUNCH;
            addr_d  = sel_addr_s;
            burst_d = sel_burst_s;
            be_d    = sel_be_s;
            bs_d    = sel_bs_s;
            case (sel_op_s)
              OP_READ:   rd_d = 1'b1;
              OP_WRITE:  wr_d = 1'b1;
              OP_SWITCH: sw_d = 1'b1;
              default:   rd_d = 1'b0;
            endcase
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT_DONE;
        cnt_d   = '0;
      end
      ST_WAIT_DONE: begin
        // A done arriving on the timeout cycle still completes normally.
        if (dma_operation_done_i) begin
          rbs_d   = dma_block_size_in_i;
          done_d  = ch_onehot(ch_q);
          state_d = ST_RESPOND;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          sticky_d = 1'b1;
          err_d    = ch_onehot(ch_q);
          state_d  = ST_RESPOND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight command silently.
  always_ff @(posedge system_clk_i) begin
    if (system_reset_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ch_q     <= '0;
      sticky_q <= 1'b0;
      addr_q   <= '0;
      burst_q  <= '0;
      be_q     <= 4'h0;
      bs_q     <= 8'h00;
      rbs_q    <= 8'h00;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      sw_q     <= 1'b0;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
      sticky_q <= sticky_d;
      addr_q   <= addr_d;
      burst_q  <= burst_d;
      be_q     <= be_d;
      bs_q     <= bs_d;
      rbs_q    <= rbs_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      sw_q     <= sw_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign rsp_done_o                 = done_q;
  assign rsp_error_o                = err_q;
  assign rsp_block_size_o           = rbs_q;
  assign dma_address_o              = addr_q;
  assign dma_burst_size_out_o       = burst_q;
  assign dma_byte_enable_o          = be_q;
  assign dma_block_size_out_o       = bs_q;
  assign dma_launch_read_o          = rd_q;
  assign dma_launch_write_o         = wr_q;
  assign dma_launch_simple_switch_o = sw_q;
  assign status_out_o               = pack_status(state_q, sticky_q, 4'(last_idx_s));

endmodule

// File: tb/tb_jtag_dma_arbiter.sv
// Directed bench for jtag_dma_arbiter (N_CH=4, TIMEOUT_CYCLES=8): a per-cycle
// vector table plus hand-built sequences for round-robin, reset and timeout races.
module tb_jtag_dma_arbiter;

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  valid;
    logic [7:0]  op;
    logic        busy;
    logic        done;
    logic [7:0]  bin;
    logic [3:0]  e_ready;
    logic [3:0]  e_done;
    logic [3:0]  e_err;
    logic [2:0]  e_launch;
    logic [7:0]  e_status;
    logic [7:0]  e_rbs;
    logic [31:0] e_addr;
    logic [19:0] e_fields;
  } vec_t;

  logic         clk;
  logic         system_reset;
  logic [3:0]   cmd_valid;
  logic [3:0]   cmd_ready;
  logic [7:0]   cmd_op;
  logic [127:0] cmd_address;
  logic [31:0]  cmd_burst_size;
  logic [15:0]  cmd_byte_enable;
  logic [31:0]  cmd_block_size;
  logic [3:0]   rsp_done;
  logic [3:0]   rsp_error;
  logic [7:0]   rsp_block_size;
  logic [31:0]  dma_address;
  logic [7:0]   dma_burst_size_out;
  logic [3:0]   dma_byte_enable;
  logic [7:0]   dma_block_size_out;
  logic         dma_launch_read;
  logic         dma_launch_write;
  logic         dma_launch_simple_switch;
  logic         dma_busy;
  logic         dma_operation_done;
  logic [7:0]   dma_block_size_in;
  logic [7:0]   status_out;

  logic [31:0] ch_addr [4];
  logic [19:0] ch_f    [4];
  vec_t        tbl[$];
  int          n_vec;
  int          n_err;

  jtag_dma_arbiter #(
    .N_CH(4), .ADDR_W(32), .BURST_W(8), .TIMEOUT_CYCLES(8)
  ) dut (
    .system_clk_i              (clk),
    .system_reset_i            (system_reset),
    .cmd_valid_i               (cmd_valid),
    .cmd_ready_o               (cmd_ready),
    .cmd_op_i                  (cmd_op),
    .cmd_address_i             (cmd_address),
    .cmd_burst_size_i          (cmd_burst_size),
    .cmd_byte_enable_i         (cmd_byte_enable),
    .cmd_block_size_i          (cmd_block_size),
    .rsp_done_o                (rsp_done),
    .rsp_error_o               (rsp_error),
    .rsp_block_size_o          (rsp_block_size),
    .dma_address_o             (dma_address),
    .dma_burst_size_out_o      (dma_burst_size_out),
    .dma_byte_enable_o         (dma_byte_enable),
    .dma_block_size_out_o      (dma_block_size_out),
    .dma_launch_read_o         (dma_launch_read),
    .dma_launch_write_o        (dma_launch_write),
    .dma_launch_simple_switch_o(dma_launch_simple_switch),
    .dma_busy_i                (dma_busy),
    .dma_operation_done_i      (dma_operation_done),
    .dma_block_size_in_i       (dma_block_size_in),
    .status_out_o              (status_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] oh(input int c);
    return 4'(4'b0001 << c);
  endfunction

  function automatic vec_t mk(input string nm, input logic rst, input logic [3:0] vl,
                              input logic [7:0] op, input logic bz, input logic dn,
                              input logic [7:0] bi, input logic [3:0] er, input logic [3:0] ed,
                              input logic [3:0] ee, input logic [2:0] el, input logic [7:0] es,
                              input logic [7:0] erb, input logic [31:0] ea, input logic [19:0] ef);
    vec_t v;
    v.name = nm; v.rst = rst; v.valid = vl; v.op = op; v.busy = bz; v.done = dn; v.bin = bi;
    v.e_ready = er; v.e_done = ed; v.e_err = ee; v.e_launch = el; v.e_status = es;
    v.e_rbs = erb; v.e_addr = ea; v.e_fields = ef;
    return v;
  endfunction

  // Drive one cycle of inputs at the falling edge and compare shortly after.
  task automatic apply(input vec_t v);
    logic [82:0] got;
    logic [82:0] exp;
    @(negedge clk);
    system_reset       = v.rst;
    cmd_valid          = v.valid;
    cmd_op             = v.op;
    dma_busy           = v.busy;
    dma_operation_done = v.done;
    dma_block_size_in  = v.bin;
    #1;
    got = {cmd_ready, rsp_done, rsp_error,
           dma_launch_simple_switch, dma_launch_write, dma_launch_read,
           status_out, rsp_block_size, dma_address,
           dma_burst_size_out, dma_byte_enable, dma_block_size_out};
    exp = {v.e_ready, v.e_done, v.e_err, v.e_launch, v.e_status, v.e_rbs, v.e_addr, v.e_fields};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got ready=%h done=%h err=%h launch=%b status=%h rbs=%h addr=%h fields=%h ; want ready=%h done=%h err=%h launch=%b status=%h rbs=%h addr=%h fields=%h",
               v.name, cmd_ready, rsp_done, rsp_error,
               {dma_launch_simple_switch, dma_launch_write, dma_launch_read},
               status_out, rsp_block_size, dma_address,
               {dma_burst_size_out, dma_byte_enable, dma_block_size_out},
               v.e_ready, v.e_done, v.e_err, v.e_launch, v.e_status, v.e_rbs, v.e_addr, v.e_fields);
    end
  endtask

  initial begin
    int          ch;
    int          prev;
    logic [7:0]  p_rbs;
    logic [31:0] p_addr;
    logic [19:0] p_f;
    logic [7:0]  rbs_now;

    n_vec = 0;
    n_err = 0;
    ch_addr[0] = 32'h1000_0000; ch_f[0] = {8'h10, 4'hF, 8'h11};
    ch_addr[1] = 32'h2000_0100; ch_f[1] = {8'h20, 4'h3, 8'h22};
    ch_addr[2] = 32'h3000_0200; ch_f[2] = {8'h30, 4'hC, 8'h33};
    ch_addr[3] = 32'h4000_0300; ch_f[3] = {8'h40, 4'h1, 8'h44};
    cmd_address     = {ch_addr[3], ch_addr[2], ch_addr[1], ch_addr[0]};
    cmd_burst_size  = {ch_f[3][19:12], ch_f[2][19:12], ch_f[1][19:12], ch_f[0][19:12]};
    cmd_byte_enable = {ch_f[3][11:8], ch_f[2][11:8], ch_f[1][11:8], ch_f[0][11:8]};
    cmd_block_size  = {ch_f[3][7:0], ch_f[2][7:0], ch_f[1][7:0], ch_f[0][7:0]};

    // Read on ch0, busy blocking, write on ch1 that times out, reserved op on ch1.
    tbl.push_back(mk("reset_state", 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 4'h0, 3'b000, 8'h30, 8'h00, 32'h0, 20'h0));
    tbl.push_back(mk("rd_accept",   1'b0, 4'h1, 8'h00, 1'b0, 1'b0, 8'h00, 4'h1, 4'h0, 4'h0, 3'b000, 8'h30, 8'h00, 32'h0, 20'h0));
    tbl.push_back(mk("rd_launch",   1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 4'h0, 3'b001, 8'h01, 8'h00, ch_addr[0], ch_f[0]));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk("rd_wait",   1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 4'h0, 3'b000, 8'h02, 8'h00, ch_addr[0], ch_f[0]));
    tbl.push_back(mk("rd_done_in",  1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 8'h20, 4'h0, 4'h0, 4'h0, 3'b000, 8'h02, 8'h00, ch_addr[0], ch_f[0]));
    tbl.push_back(mk("rd_respond",  1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 4'h1, 4'h0, 3'b000, 8'h03, 8'h20, ch_addr[0], ch_f[0]));
    tbl.push_back(mk("busy_block",  1'b0, 4'h2, 8'h04, 1'b1, 1'b1, 8'h99, 4'h0, 4'h0, 4'h0, 3'b000, 8'h00, 8'h20, ch_addr[0], ch_f[0]));
    tbl.push_back(mk("wr_accept",   1'b0, 4'h2, 8'h04, 1'b0, 1'b0, 8'h00, 4'h2, 4'h0, 4'h0, 3'b000, 8'h00, 8'h20, ch_addr[0], ch_f[0]));
    tbl.push_back(mk("wr_launch",   1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 8'h77, 4'h0, 4'h0, 4'h0, 3'b010, 8'h11, 8'h20, ch_addr[1], ch_f[1]));
    for (int i = 0; i < 9; i++)
      tbl.push_back(mk("to_wait",   1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 4'h0, 3'b000, 8'h12, 8'h20, ch_addr[1], ch_f[1]));
    tbl.push_back(mk("timeout_err", 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 4'h2, 3'b000, 8'h1B, 8'h20, ch_addr[1], ch_f[1]));
    tbl.push_back(mk("rsv_accept",  1'b0, 4'h2, 8'h0C, 1'b0, 1'b0, 8'h00, 4'h2, 4'h0, 4'h0, 3'b000, 8'h18, 8'h20, ch_addr[1], ch_f[1]));
    tbl.push_back(mk("rsv_err",     1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 4'h2, 3'b000, 8'h1B, 8'h20, ch_addr[1], ch_f[1]));
    tbl.push_back(mk("rsv_idle",    1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 4'h0, 3'b000, 8'h18, 8'h20, ch_addr[1], ch_f[1]));
    // Reset while waiting on the DMA, with a done arriving in the reset cycle.
    tbl.push_back(mk("rst_accept",  1'b0, 4'h1, 8'h01, 1'b0, 1'b0, 8'h00, 4'h1, 4'h0, 4'h0, 3'b000, 8'h18, 8'h20, ch_addr[1], ch_f[1]));
    tbl.push_back(mk("rst_launch",  1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 4'h0, 3'b010, 8'h09, 8'h20, ch_addr[0], ch_f[0]));
    tbl.push_back(mk("rst_wait",    1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 4'h0, 3'b000, 8'h0A, 8'h20, ch_addr[0], ch_f[0]));
    tbl.push_back(mk("rst_assert",  1'b1, 4'h0, 8'h00, 1'b0, 1'b1, 8'h55, 4'h0, 4'h0, 4'h0, 3'b000, 8'h0A, 8'h20, ch_addr[0], ch_f[0]));
    tbl.push_back(mk("rst_cleared", 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 4'h0, 3'b000, 8'h30, 8'h00, 32'h0, 20'h0));

    system_reset       = 1'b1;
    cmd_valid          = 4'h0;
    cmd_op             = 8'h00;
    dma_busy           = 1'b0;
    dma_operation_done = 1'b0;
    dma_block_size_in  = 8'h00;
    repeat (3) @(posedge clk);

    foreach (tbl[i]) apply(tbl[i]);

    // All four channels valid: grants rotate 0,1,2,3,0 with done on the first wait cycle.
    prev   = 3;
    p_rbs  = 8'h00;
    p_addr = 32'h0;
    p_f    = 20'h0;
    for (int g = 0; g < 5; g++) begin
      ch      = g % 4;
      rbs_now = 8'(8'h40 + g);
      apply(mk("rr_accept", 1'b0, 4'hF, 8'h00, 1'b0, 1'b0, 8'h00, oh(ch), 4'h0, 4'h0, 3'b000,
               {4'(prev), 4'h0}, p_rbs, p_addr, p_f));
      apply(mk("rr_launch", 1'b0, 4'hF, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 4'h0, 3'b001,
               {4'(ch), 4'h1}, p_rbs, ch_addr[ch], ch_f[ch]));
      apply(mk("rr_wait", 1'b0, 4'hF, 8'h00, 1'b0, 1'b1, rbs_now, 4'h0, 4'h0, 4'h0, 3'b000,
               {4'(ch), 4'h2}, p_rbs, ch_addr[ch], ch_f[ch]));
      apply(mk("rr_respond", 1'b0, 4'hF, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, oh(ch), 4'h0, 3'b000,
               {4'(ch), 4'h3}, rbs_now, ch_addr[ch], ch_f[ch]));
      prev   = ch;
      p_rbs  = rbs_now;
      p_addr = ch_addr[ch];
      p_f    = ch_f[ch];
    end

    // Switch on ch2 (ch1 idle is skipped); done lands on the timeout cycle.
    apply(mk("race_accept", 1'b0, 4'h4, 8'h20, 1'b0, 1'b0, 8'h00, 4'h4, 4'h0, 4'h0, 3'b000, 8'h00, p_rbs, p_addr, p_f));
    apply(mk("race_launch", 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 4'h0, 3'b100, 8'h21, p_rbs, ch_addr[2], ch_f[2]));
    for (int i = 0; i < 8; i++)
      apply(mk("race_wait", 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 4'h0, 3'b000, 8'h22, p_rbs, ch_addr[2], ch_f[2]));
    apply(mk("race_done_in", 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 8'h66, 4'h0, 4'h0, 4'h0, 3'b000, 8'h22, p_rbs, ch_addr[2], ch_f[2]));
    apply(mk("race_respond", 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 4'h4, 4'h0, 3'b000, 8'h23, 8'h66, ch_addr[2], ch_f[2]));
    apply(mk("race_idle", 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 4'h0, 3'b000, 8'h20, 8'h66, ch_addr[2], ch_f[2]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
